// File: rtl/coinc_trigger.sv
// ---------------------------------------------------------------------------
// coinc_trigger
//
// Coincidence trigger stage. It sits behind the per-channel delay pipelines
// and feeds the trigger output / counting logic. For every channel it
// detects the rising edge of the hit bit and stretches that edge into a
// programmable coincidence window. When enough windows overlap, the block
// fires a one-cycle trigger and then holds off for a programmable deadtime.
//
// Parameters
//   N_IN          number of input channels (1..8)
//   CNT_W         width of the accepted-trigger counter
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst           asynchronous active-high reset
//   in            delayed hit bits, one per channel
//   in_live       run-live qualifier; low holds the block idle
//   user_mask     per-channel enable (1 = channel takes part)
//   user_width    coincidence window length minus one, in clocks
//   user_mult     required multiplicity; 0 disables triggering
//   user_deadtime deadtime after a trigger, in clocks
//   trig_out      registered one-cycle trigger pulse
//   busy          registered, high whenever the FSM is not idle
//   trig_count    number of triggers issued, saturating
//
// Build option
//   COINC_TRIG_COUNT_EN  when defined, trig_count counts FIRE cycles and
//                        saturates at all-ones; otherwise the counter is
//                        not built and trig_count is tied to zero.
// ---------------------------------------------------------------------------
module coinc_trigger #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in,
    input  logic             in_live,
    input  logic [N_IN-1:0]  user_mask,
    input  logic [3:0]       user_width,
    input  logic [2:0]       user_mult,
    input  logic [7:0]       user_deadtime,
    output logic             trig_out,
    output logic             busy,
    output logic [CNT_W-1:0] trig_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_t;

    logic [N_IN-1:0] in_prev;
    logic [N_IN-1:0] edge_q;
    logic [4:0]      scnt [N_IN];
    logic [N_IN-1:0] stretched;
    logic [3:0]      mult;
    logic            coinc;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      dcnt_q;
    logic [7:0]      dcnt_d;

    // Window load value is one more than the programmed width, so a width
    // of zero still gives a single-cycle window.
    logic [4:0]      window_len;

    assign window_len = {1'b0, user_width} + 5'd1;

    // Previous-sample register for edge detection. It keeps tracking the
    // inputs even while the run is not live, so that raising in_live with
    // inputs already high does not manufacture fresh edges. Reset clears it
    // to zero, which means an input that is high at reset release counts as
    // an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_prev <= '0;
        end else begin
            in_prev <= in;
        end
    end

    // Registered rising-edge detect, qualified by the channel mask. A channel
    // held high produces exactly one edge because in_prev follows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= '0;
        end else if (!in_live) begin
            edge_q <= '0;
        end else begin
            edge_q <= in & ~in_prev & user_mask;
        end
    end

    // Per-channel window stretcher. An edge (re)loads the counter, so a
    // retrigger inside an open window extends it rather than being lost.
    // Otherwise the counter runs down to zero and stops there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                scnt[i] <= 5'd0;
            end
        end else if (!in_live) begin
            for (int i = 0; i < N_IN; i++) begin
                scnt[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (edge_q[i]) begin
                    scnt[i] <= window_len;
                end else if (scnt[i] != 5'd0) begin
                    scnt[i] <= scnt[i] - 5'd1;
                end
            end
        end
    end

    // Window flags and their population count. The coincidence condition is
    // met when the number of open windows reaches the requested multiplicity;
    // a multiplicity of zero switches triggering off entirely.
    always_comb begin
        stretched = '0;
        mult      = 4'd0;
        for (int i = 0; i < N_IN; i++) begin
            stretched[i] = (scnt[i] != 5'd0);
            mult         = mult + {3'b000, stretched[i]};
        end
    end

    assign coinc = (user_mult != 3'd0) && (mult >= {1'b0, user_mult});

    // Trigger state machine, next-state half. IDLE waits for a coincidence,
    // FIRE lasts one cycle and arms the deadtime counter, DEAD counts down so
    // that it lasts exactly user_deadtime cycles. Coincidences that show up
    // outside IDLE are simply ignored. Dropping in_live overrides everything
    // and parks the machine in IDLE with the deadtime counter cleared.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            IDLE: begin
                if (coinc) begin
                    state_d = FIRE;
                end
            end

            FIRE: begin
                if (user_deadtime == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d  = user_deadtime;
                    state_d = DEAD;
                end
            end

            DEAD: begin
                dcnt_d = dcnt_q - 8'd1;
                if (dcnt_q <= 8'd1) begin
                    dcnt_d  = 8'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                dcnt_d  = 8'd0;
            end
        endcase

        if (!in_live) begin
            state_d = IDLE;
            dcnt_d  = 8'd0;
        end
    end

    // Trigger state machine, register half. trig_out and busy are decoded
    // from the next state and registered here, so both outputs change on the
    // same edge as the state itself and nothing combinational reaches a port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dcnt_q   <= 8'd0;
            trig_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            trig_out <= (state_d == FIRE);
            busy     <= (state_d != IDLE);
        end
    end

`ifdef COINC_TRIG_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;

    // Accepted-trigger counter. It steps on the same edge that raises
    // trig_out, so the count always agrees with the pulses seen so far. It
    // sticks at all-ones instead of wrapping, and only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if ((state_d == FIRE) && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    assign trig_count = count_q;
`else
    assign trig_count = '0;
`endif

endmodule

// File: tb/tb_coinc_trigger.sv
// ---------------------------------------------------------------------------
// tb_coinc_trigger
//
// Directed self-checking bench for coinc_trigger (N_IN = 4, CNT_W = 4).
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
// Expected trigger counts depend on whether COINC_TRIG_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_coinc_trigger;

    localparam int N_IN  = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [N_IN-1:0]  in;
    logic             in_live;
    logic [N_IN-1:0]  user_mask;
    logic [3:0]       user_width;
    logic [2:0]       user_mult;
    logic [7:0]       user_deadtime;
    logic             trig_out;
    logic             busy;
    logic [CNT_W-1:0] trig_count;

    int checks   = 0;
    int failures = 0;
    int exp_trigs = 0;
    int pulses;
    int busy_cnt;
    logic trig_hist [64];
    logic busy_hist [64];

    coinc_trigger #(
        .N_IN (N_IN),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .in_live      (in_live),
        .user_mask    (user_mask),
        .user_width   (user_width),
        .user_mult    (user_mult),
        .user_deadtime(user_deadtime),
        .trig_out     (trig_out),
        .busy         (busy),
        .trig_count   (trig_count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected counter value after n triggers since reset.
    function automatic int expCount(input int n);
`ifdef COINC_TRIG_COUNT_EN
        return (n > 15) ? 15 : n;
`else
        return 0;
`endif
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a hit pattern for n cycles and count trigger pulses seen.
    task automatic applyStimulus(input logic [N_IN-1:0] v, input int n, output int npulse);
        in = v;
        npulse = 0;
        repeat (n) begin
            tick();
            if (trig_out) npulse++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Clear every window and the FSM by dropping in_live for two cycles.
    task automatic flushLive();
        in      = '0;
        in_live = 1'b0;
        tick();
        tick();
        in_live = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        in            = '0;
        in_live       = 1'b1;
        user_mask     = 4'hF;
        user_width    = 4'd3;
        user_mult     = 3'd2;
        user_deadtime = 8'd0;

        // Reset state
        tick();
        tick();
        checkOutput("reset_trig", 32'(trig_out), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_count", 32'(trig_count), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Latency and window: ch0 at E, ch1 at E+3, width 3 -> trigger after E+5
        $display("[TB] latency/window");
        in = 4'b0001;
        tick();                         // E
        tick();                         // E+1
        tick();                         // E+2
        checkOutput("lat_early_trig", 32'(trig_out), 32'd0);
        in = 4'b0011;
        tick();                         // E+3
        tick();                         // E+4
        checkOutput("lat_e4_trig", 32'(trig_out), 32'd0);
        tick();                         // E+5
        checkOutput("lat_e5_trig", 32'(trig_out), 32'd1);
        checkOutput("lat_e5_busy", 32'(busy), 32'd1);
        exp_trigs += 1;
        checkOutput("lat_e5_count", 32'(trig_count), 32'(expCount(exp_trigs)));
        tick();                         // E+6
        checkOutput("lat_e6_trig", 32'(trig_out), 32'd0);
        checkOutput("lat_e6_busy", 32'(busy), 32'd0);
        applyStimulus(4'b0011, 4, pulses);
        checkOutput("lat_single", 32'(pulses), 32'd0);
        applyStimulus(4'b0000, 8, pulses);

        // Edge separation of 4 exceeds width 3 -> no trigger
        in = 4'b0001;
        tick();
        tick();
        tick();
        tick();                         // E+3
        applyStimulus(4'b0011, 10, pulses);
        checkOutput("window_d4_none", 32'(pulses), 32'd0);
        applyStimulus(4'b0000, 8, pulses);

        // Multiplicity and mask with single-cycle windows
        $display("[TB] multiplicity/mask");
        user_width = 4'd0;
        user_mult  = 3'd4;
        user_mask  = 4'b1011;
        applyStimulus(4'b1111, 6, pulses);
        checkOutput("mult4_mask1011", 32'(pulses), 32'd0);
        applyStimulus(4'b0000, 3, pulses);
        user_mask = 4'hF;
        applyStimulus(4'b1111, 6, pulses);
        checkOutput("mult4_maskF", 32'(pulses), 32'd1);
        exp_trigs += 1;
        applyStimulus(4'b0000, 3, pulses);
        user_mult = 3'd3;
        user_mask = 4'b1011;
        applyStimulus(4'b1111, 6, pulses);
        checkOutput("mult3_mask1011", 32'(pulses), 32'd1);
        exp_trigs += 1;
        applyStimulus(4'b0000, 3, pulses);
        user_mult = 3'd0;
        user_mask = 4'hF;
        applyStimulus(4'b1111, 6, pulses);
        checkOutput("mult0_disabled", 32'(pulses), 32'd0);
        applyStimulus(4'b0000, 3, pulses);
        checkOutput("mult_count", 32'(trig_count), 32'(expCount(exp_trigs)));

        // in_live dropped during DEAD
        $display("[TB] in_live");
        user_mult     = 3'd2;
        user_width    = 4'd3;
        user_deadtime = 8'd5;
        in = 4'b0011;
        tick();                         // E
        tick();                         // E+1
        tick();                         // E+2
        checkOutput("live_fire", 32'(trig_out), 32'd1);
        exp_trigs += 1;
        tick();                         // E+3
        checkOutput("live_dead_busy", 32'(busy), 32'd1);
        in_live = 1'b0;
        tick();
        checkOutput("live_low_busy", 32'(busy), 32'd0);
        checkOutput("live_low_count", 32'(trig_count), 32'(expCount(exp_trigs)));
        applyStimulus(4'b0011, 4, pulses);
        checkOutput("live_low_notrig", 32'(pulses), 32'd0);
        in_live = 1'b1;
        applyStimulus(4'b0011, 8, pulses);
        checkOutput("live_steady_notrig", 32'(pulses), 32'd0);
        applyStimulus(4'b0000, 1, pulses);
        applyStimulus(4'b0011, 10, pulses);
        checkOutput("live_new_edge", 32'(pulses), 32'd1);
        exp_trigs += 1;
        applyStimulus(4'b0000, 3, pulses);

        // Reset in the middle of DEAD, then an input high at release
        $display("[TB] reset mid-deadtime");
        in = 4'b0011;
        tick();
        tick();
        tick();
        exp_trigs += 1;
        tick();                         // now in DEAD
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        checkOutput("pre_reset_count", 32'(trig_count), 32'(expCount(exp_trigs)));
        rst           = 1'b1;
        in            = 4'b0001;
        user_mult     = 3'd1;
        user_width    = 4'd0;
        user_deadtime = 8'd0;
        #1;
        checkOutput("async_rst_trig", 32'(trig_out), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_count", 32'(trig_count), 32'd0);
        exp_trigs = 0;
        tick();
        rst = 1'b0;
        tick();                         // E: held-high input seen as edge
        checkOutput("rel_e0_trig", 32'(trig_out), 32'd0);
        tick();
        checkOutput("rel_e1_trig", 32'(trig_out), 32'd0);
        tick();
        checkOutput("rel_e2_trig", 32'(trig_out), 32'd1);
        exp_trigs += 1;
        applyStimulus(4'b0001, 6, pulses);
        checkOutput("rel_held_single", 32'(pulses), 32'd0);

        // Counter saturation: 20 more triggers, one every two cycles
        $display("[TB] counter");
        applyStimulus(4'b0000, 1, pulses);
        pulses = 0;
        for (int i = 0; i < 42; i++) begin
            in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
            if (trig_out) pulses++;
            if (i == 26) begin
                checkOutput("cnt_mid_trig", 32'(trig_out), 32'd1);
                checkOutput("cnt_mid_count", 32'(trig_count), 32'(expCount(exp_trigs + 13)));
            end
        end
        checkOutput("cnt_pulses", 32'(pulses), 32'd20);
        exp_trigs += 20;
        flushLive();
        checkOutput("cnt_saturated", 32'(trig_count), 32'(expCount(exp_trigs)));

        // Deadtime 5 with coincidences refreshed every 2 cycles
        $display("[TB] deadtime");
        user_mult     = 3'd2;
        user_width    = 4'd15;
        user_deadtime = 8'd5;
        for (int i = 0; i < 40; i++) begin
            in = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            tick();
            trig_hist[i] = trig_out;
            busy_hist[i] = busy;
        end
        flushLive();
        pulses   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (trig_hist[i]) pulses++;
        end
        for (int i = 2; i < 9; i++) begin
            if (busy_hist[i]) busy_cnt++;
        end
        checkOutput("dt5_first", 32'(trig_hist[2]), 32'd1);
        checkOutput("dt5_gap", 32'(trig_hist[8]), 32'd0);
        checkOutput("dt5_second", 32'(trig_hist[9]), 32'd1);
        checkOutput("dt5_busy_last", 32'(busy_hist[7]), 32'd1);
        checkOutput("dt5_busy_idle", 32'(busy_hist[8]), 32'd0);
        checkOutput("dt5_busy_len", 32'(busy_cnt), 32'd6);
        checkOutput("dt5_pulses", 32'(pulses), 32'd6);
        exp_trigs += 6;

        // Deadtime 0: trigger, one re-arm cycle, trigger again
        user_deadtime = 8'd0;
        for (int i = 0; i < 20; i++) begin
            in = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            tick();
            trig_hist[i] = trig_out;
        end
        flushLive();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (trig_hist[i]) pulses++;
        end
        checkOutput("dt0_first", 32'(trig_hist[2]), 32'd1);
        checkOutput("dt0_rearm", 32'(trig_hist[3]), 32'd0);
        checkOutput("dt0_second", 32'(trig_hist[4]), 32'd1);
        checkOutput("dt0_pulses", 32'(pulses), 32'd9);
        exp_trigs += 9;
        checkOutput("final_count", 32'(trig_count), 32'(expCount(exp_trigs)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
